rob_multi_port: RTL and testbench

//  Parametrised reorder buffer: in-order allocate, out-of-order completion over NUM_WB result buses, in-order retire up to COMMIT_W/cycle.

---
 rtl/rob_multi_port_pkg.sv | 10 +
 rtl/rob_multi_port_commit_sel.sv | 45 ++++
 rtl/rob_multi_port.sv | 209 ++++++++++++++++++++
 tb/tb_rob_multi_port.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_multi_port_pkg.sv
// rob_multi_port_pkg: entry kind codes and default sizing shared by the reorder buffer files
package rob_multi_port_pkg;
    localparam int ROB_DEPTH = 16;
    typedef enum logic [1:0] {
        K_ALU    = 2'd0,
        K_BRANCH = 2'd1,
        K_STORE  = 2'd2,
        K_DONE   = 2'd3
    } kind_e;
endpackage

// File: rtl/rob_multi_port_commit_sel.sv
// rob_commit_sel: picks the oldest retirable lanes and detects a mispredicted branch among them
module rob_commit_sel
    import rob_multi_port_pkg::*;
#(
    parameter int COMMIT_W = 2
) (
    input  logic [COMMIT_W-1:0]       ready_i,
    input  logic [COMMIT_W-1:0][1:0]  kind_i,
    input  logic [COMMIT_W-1:0]       taken_i,
    input  logic [COMMIT_W-1:0]       pred_i,
    input  logic [COMMIT_W-1:0][31:0] tgt_t_i,
    input  logic [COMMIT_W-1:0][31:0] tgt_nt_i,
    input  logic                      st_ack_i,
    output logic [COMMIT_W-1:0]       retire_o,
    output logic                      flush_o,
    output logic [31:0]               flush_pc_o,
    output logic                      st_commit_o
);
    logic go, seen_br;
    always_comb begin
        retire_o   = '0;
        flush_o    = 1'b0;
        flush_pc_o = '0;
        go         = 1'b1;
        seen_br    = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            // a store only leaves from lane 0, where the LSB handshake is visible
            if (!ready_i[k] || (kind_i[k] == K_STORE && (k != 0 || !st_ack_i)) ||
                (kind_i[k] == K_BRANCH && seen_br))
                go = 1'b0;
            if (go) begin
                retire_o[k] = 1'b1;
                if (kind_i[k] == K_BRANCH) begin
                    seen_br = 1'b1;
                    if (taken_i[k] != pred_i[k]) begin
                        flush_o    = 1'b1;
                        flush_pc_o = taken_i[k] ? tgt_t_i[k] : tgt_nt_i[k];
                        go         = 1'b0;
                    end
                end
            end
        end
    end
    assign st_commit_o = ready_i[0] && kind_i[0] == K_STORE;
endmodule

// File: rtl/rob_multi_port.sv
// rob_multi_port: reorder buffer with multi-bus writeback, wide in-order commit and store handshake
module rob_multi_port
    import rob_multi_port_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [1:0]                issue_kind,
    input  logic [4:0]                issue_rd,
    input  logic [31:0]               issue_value,
    input  logic                      issue_pred,
    input  logic [31:0]               issue_tgt_t,
    input  logic [31:0]               issue_tgt_nt,
    output logic [IDX_W-1:0]          issue_tag,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]   wb_tag,
    input  logic [NUM_WB*32-1:0]      wb_value,
    input  logic [IDX_W-1:0]          q_tag1,
    input  logic [IDX_W-1:0]          q_tag2,
    output logic                      q_rdy1,
    output logic                      q_rdy2,
    output logic [31:0]               q_val1,
    output logic [31:0]               q_val2,
    output logic [COMMIT_W-1:0]       cm_valid,
    output logic [COMMIT_W*5-1:0]     cm_rd,
    output logic [COMMIT_W*IDX_W-1:0] cm_tag,
    output logic [COMMIT_W*32-1:0]    cm_value,
    output logic                      st_commit,
    input  logic                      st_ack,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic [IDX_W:0]            count
);
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, pred_q;
    kind_e kind_q [DEPTH];
    logic [4:0] rd_q [DEPTH];
    logic [31:0] value_q [DEPTH];
    logic [31:0] tgt_t_q [DEPTH];
    logic [31:0] tgt_nt_q [DEPTH];
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0] count_q, count_d, n_ret;
    logic [NUM_WB-1:0][IDX_W-1:0] wbt;
    logic [NUM_WB-1:0][31:0] wbv;
    logic [COMMIT_W-1:0][IDX_W-1:0] lane_idx;
    logic [COMMIT_W-1:0][1:0] lane_kind;
    logic [COMMIT_W-1:0][31:0] lane_tgt_t, lane_tgt_nt;
    logic [COMMIT_W-1:0] lane_rdy, lane_taken, lane_pred, retire;
    logic [1:0][IDX_W-1:0] q_tag;
    logic [1:0] q_hit;
    logic [1:0][31:0] q_res;
    logic iss_acc;

    assign wbt         = wb_tag;
    assign wbv         = wb_value;
    assign issue_ready = count_q < (IDX_W+1)'(DEPTH);
    assign issue_tag   = tail_q;
    assign count       = count_q;
    assign iss_acc     = issue_valid && issue_ready;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            lane_idx[k]    = head_q + IDX_W'(k);
            lane_rdy[k]    = valid_q[lane_idx[k]] && done_q[lane_idx[k]];
            lane_kind[k]   = kind_q[lane_idx[k]];
            lane_taken[k]  = value_q[lane_idx[k]][0];
            lane_pred[k]   = pred_q[lane_idx[k]];
            lane_tgt_t[k]  = tgt_t_q[lane_idx[k]];
            lane_tgt_nt[k] = tgt_nt_q[lane_idx[k]];
        end
    end

    rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
        .ready_i    (lane_rdy),
        .kind_i     (lane_kind),
        .taken_i    (lane_taken),
        .pred_i     (lane_pred),
        .tgt_t_i    (lane_tgt_t),
        .tgt_nt_i   (lane_tgt_nt),
        .st_ack_i   (st_ack),
        .retire_o   (retire),
        .flush_o    (flush),
        .flush_pc_o (flush_pc),
        .st_commit_o(st_commit)
    );

    assign cm_valid = retire;

    // branch and store lanes retire as markers carrying no register result
    always_comb begin
        cm_rd    = '0;
        cm_tag   = '0;
        cm_value = '0;
        n_ret    = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (retire[k]) begin
                n_ret = n_ret + (IDX_W+1)'(1);
                cm_tag[k*IDX_W +: IDX_W] = lane_idx[k];
                if (lane_kind[k] == K_ALU || lane_kind[k] == K_DONE) begin
                    cm_rd[k*5 +: 5]     = rd_q[lane_idx[k]];
                    cm_value[k*32 +: 32] = value_q[lane_idx[k]];
                end
            end
        end
    end

    assign head_d  = head_q + n_ret[IDX_W-1:0];
    assign tail_d  = tail_q + IDX_W'(iss_acc);
    assign count_d = count_q + (IDX_W+1)'(iss_acc) - n_ret;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (retire[k]) begin
                valid_d[lane_idx[k]] = 1'b0;
                done_d[lane_idx[k]]  = 1'b0;
            end
        end
        for (int b = 0; b < NUM_WB; b++) begin
            if (wb_valid[b]) done_d[wbt[b]] = 1'b1;
        end
        if (iss_acc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = issue_kind == K_DONE;
        end
    end

    // bypass priority: stored result, then lower-numbered bus, then a same-cycle DONE issue
    assign q_tag = {q_tag2, q_tag1};
    always_comb begin
        q_hit = '0;
        q_res = '0;
        for (int j = 0; j < 2; j++) begin
            if (iss_acc && issue_kind == K_DONE && tail_q == q_tag[j]) begin
                q_hit[j] = 1'b1;
                q_res[j] = issue_value;
            end
            for (int b = NUM_WB - 1; b >= 0; b--) begin
                if (wb_valid[b] && wbt[b] == q_tag[j]) begin
                    q_hit[j] = 1'b1;
                    q_res[j] = wbv[b];
                end
            end
            if (done_q[q_tag[j]]) begin
                q_hit[j] = 1'b1;
                q_res[j] = value_q[q_tag[j]];
            end
        end
    end
    assign q_rdy1 = q_hit[0];
    assign q_rdy2 = q_hit[1];
    assign q_val1 = q_res[0];
    assign q_val2 = q_res[1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                valid_q <= '0;
                done_q  <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
                valid_q <= valid_d;
                done_q  <= done_d;
                for (int b = 0; b < NUM_WB; b++) begin
                    if (wb_valid[b] && (rd_q[wbt[b]] != 5'd0 || kind_q[wbt[b]] == K_BRANCH))
                        value_q[wbt[b]] <= wbv[b];
                end
                if (iss_acc) begin
                    kind_q[tail_q]   <= kind_e'(issue_kind);
                    rd_q[tail_q]     <= issue_rd;
                    value_q[tail_q]  <= issue_kind == K_DONE ? issue_value : 32'd0;
                    pred_q[tail_q]   <= issue_pred;
                    tgt_t_q[tail_q]  <= issue_tgt_t;
                    tgt_nt_q[tail_q] <= issue_tgt_nt;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush) begin
            for (int b = 0; b < NUM_WB; b++) begin
                if (wb_valid[b]) begin
                    assert (valid_q[wbt[b]] && !done_q[wbt[b]]);
                    for (int c = b + 1; c < NUM_WB; c++)
                        assert (!(wb_valid[c] && wbt[c] == wbt[b]));
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_port.sv
// tb_rob_multi_port: scoreboard plus vector-table bench for the reorder buffer
module tb_rob_multi_port;
    localparam int IW = 4;

    logic clk_in = 1'b0, rst_in, rdy_in;
    logic issue_valid, issue_ready, issue_pred;
    logic [1:0] issue_kind;
    logic [4:0] issue_rd;
    logic [31:0] issue_value, issue_tgt_t, issue_tgt_nt;
    logic [IW-1:0] issue_tag, q_tag1, q_tag2;
    logic [1:0] wb_valid, cm_valid;
    logic [2*IW-1:0] wb_tag, cm_tag;
    logic [63:0] wb_value, cm_value;
    logic q_rdy1, q_rdy2, st_commit, st_ack, flush;
    logic [31:0] q_val1, q_val2, flush_pc;
    logic [9:0] cm_rd;
    logic [IW:0] count;

    rob_multi_port dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
        .issue_rd(issue_rd), .issue_value(issue_value), .issue_pred(issue_pred),
        .issue_tgt_t(issue_tgt_t), .issue_tgt_nt(issue_tgt_nt), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .q_tag1(q_tag1), .q_tag2(q_tag2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_val1(q_val1), .q_val2(q_val2),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
        .st_commit(st_commit), .st_ack(st_ack), .flush(flush), .flush_pc(flush_pc),
        .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [IW-1:0] tag;
        logic [4:0]    rd;
        logic [31:0]   val;
    } exp_t;

    typedef struct {
        logic [IW-1:0] q1, q2;
        logic [1:0]    wv;
        logic [IW-1:0] t0, t1;
        logic [31:0]   d0, d1;
        logic          iv;
        logic [1:0]    ik;
        logic [31:0]   ival;
        logic          r1;
        logic [31:0]   v1;
        logic          r2;
        logic [31:0]   v2;
    } qvec_t;

    exp_t sb[$];
    qvec_t qv[7];
    int n_chk = 0, n_fail = 0, acc_cnt = 0;
    logic [31:0] plan_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: pops retirements, then pushes an accepted issue with its planned result
    task automatic monitor();
        exp_t e;
        bit m_ready;
        if (rst_in) begin
            sb.delete();
            acc_cnt = 0;
            return;
        end
        m_ready = sb.size() < 16;
        chk("count_model", count, sb.size());
        chk("issue_ready_model", issue_ready, m_ready);
        if (!rdy_in) return;
        for (int k = 0; k < 2; k++) begin
            if (cm_valid[k]) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("cm_tag", cm_tag[k*IW +: IW], e.tag);
                    chk("cm_rd", cm_rd[k*5 +: 5], e.rd);
                    chk("cm_value", cm_value[k*32 +: 32], e.val);
                end
            end
        end
        if (flush) begin
            sb.delete();
            acc_cnt = 0;
        end else if (issue_valid && m_ready) begin
            e.tag = IW'(acc_cnt);
            e.rd  = (issue_kind == 2'd0 || issue_kind == 2'd3) ? issue_rd : 5'd0;
            e.val = issue_kind == 2'd3 ? issue_value :
                    (issue_kind == 2'd0 && issue_rd != 5'd0) ? plan_val : 32'd0;
            chk("issue_tag", issue_tag, e.tag);
            sb.push_back(e);
            acc_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        monitor();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_kind = 0; issue_rd = 0; issue_value = 0; issue_pred = 0;
        issue_tgt_t = 0; issue_tgt_nt = 0; wb_valid = 0; wb_tag = 0; wb_value = 0;
        q_tag1 = 0; q_tag2 = 0; st_ack = 0;
    endtask

    task automatic set_issue(input logic v, input logic [1:0] k, input logic [4:0] rd,
                             input logic [31:0] val, input logic p,
                             input logic [31:0] tt, input logic [31:0] tn);
        issue_valid = v; issue_kind = k; issue_rd = rd; issue_value = val;
        issue_pred = p; issue_tgt_t = tt; issue_tgt_nt = tn;
    endtask

    task automatic set_wb(input logic v0, input logic [IW-1:0] t0, input logic [31:0] d0,
                          input logic v1, input logic [IW-1:0] t1, input logic [31:0] d1);
        wb_valid = {v1, v0}; wb_tag = {t1, t0}; wb_value = {d1, d0};
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        tick();
        rst_in = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        rdy_in = 1;
        rst_in = 1;
        tick();
        tick();
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_st_commit", st_commit, 0);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_q_rdy1", q_rdy1, 0);
        rst_in = 0;

        // fill all 16 slots, then drain with two buses while issue is attempted on a full ROB
        for (int i = 0; i < 16; i++) begin
            plan_val = 32'h100 + i;
            set_issue(1, 0, 5'd1, 0, 0, 0, 0);
            chk("fill_tag", issue_tag, i);
            tick();
        end
        idle();
        chk("full_count", count, 16);
        chk("full_ready", issue_ready, 0);
        for (int p = 0; p < 8; p++) begin
            set_wb(1, IW'(2*p), 32'h100 + 2*p, 1, IW'(2*p+1), 32'h101 + 2*p);
            set_issue(p < 2, 0, 5'd1, 0, 0, 0, 0);
            if (p == 1) chk("full_retire_ready", issue_ready, 0);
            tick();
            if (p == 1) chk("full_retire_count", count, 14);
        end
        idle();
        for (int c = 0; c < 20 && count != 0; c++) tick();
        chk("fill_drained", count, 0);
        chk("fill_sb_empty", sb.size(), 0);

        // out-of-order writeback, then a two-lane commit
        do_reset();
        plan_val = 32'h11; set_issue(1, 0, 5'd5, 0, 0, 0, 0); tick();
        plan_val = 32'h22; set_issue(1, 0, 5'd6, 0, 0, 0, 0); tick();
        idle();
        set_wb(0, 0, 0, 1, 1, 32'h22); tick();
        idle();
        chk("ooo_hold", cm_valid, 2'b00);
        set_wb(1, 0, 32'h11, 0, 0, 0); tick();
        idle();
        chk("ooo_cm_valid", cm_valid, 2'b11);
        chk("ooo_cm_value", cm_value, {32'h22, 32'h11});
        chk("ooo_cm_rd", cm_rd, {5'd6, 5'd5});
        tick();
        chk("ooo_count", count, 0);

        // rename query bypass vectors, evaluated with the ROB frozen
        do_reset();
        for (int i = 0; i < 4; i++) begin
            plan_val = (i == 0) ? 32'hA0 : 32'h11 * i;
            set_issue(1, 0, 5'(i + 1), 0, 0, 0, 0);
            tick();
        end
        idle();
        set_wb(1, 0, 32'hA0, 0, 0, 0); tick();
        idle();
        qv[0] = '{0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 0};
        qv[1] = '{1, 0, 2'b01, 1, 0, 32'h11, 0, 0, 0, 0, 1, 32'h11, 1, 32'hA0};
        qv[2] = '{2, 1, 2'b10, 0, 1, 0, 32'h22, 0, 0, 0, 0, 0, 1, 32'h22};
        qv[3] = '{2, 3, 2'b11, 2, 3, 32'h33, 32'h44, 0, 0, 0, 1, 32'h33, 1, 32'h44};
        qv[4] = '{3, 2, 2'b01, 3, 0, 32'hABCD, 0, 0, 0, 0, 1, 32'hABCD, 0, 0};
        qv[5] = '{4, 3, 2'b00, 0, 0, 0, 0, 1, 2'd3, 32'h77, 1, 32'h77, 0, 0};
        qv[6] = '{4, 0, 2'b00, 0, 0, 0, 0, 1, 2'd0, 32'h55, 0, 0, 1, 32'hA0};
        rdy_in = 0;
        for (int i = 0; i < 7; i++) begin
            q_tag1 = qv[i].q1; q_tag2 = qv[i].q2;
            set_wb(qv[i].wv[0], qv[i].t0, qv[i].d0, qv[i].wv[1], qv[i].t1, qv[i].d1);
            set_issue(qv[i].iv, qv[i].ik, 5'd3, qv[i].ival, 0, 0, 0);
            #1;
            chk($sformatf("q%0d_rdy1", i), q_rdy1, qv[i].r1);
            chk($sformatf("q%0d_val1", i), q_val1, qv[i].v1);
            chk($sformatf("q%0d_rdy2", i), q_rdy2, qv[i].r2);
            chk($sformatf("q%0d_val2", i), q_val2, qv[i].v2);
        end
        idle();
        set_wb(1, 2, 32'h33, 1, 3, 32'h44);
        tick();
        idle();
        q_tag1 = 2;
        #1;
        chk("freeze_q_rdy", q_rdy1, 0);
        chk("freeze_count", count, 4);
        rdy_in = 1;

        // mispredicted taken branch flushes the younger entry and the same-cycle traffic
        do_reset();
        plan_val = 32'h5; set_issue(1, 0, 5'd7, 0, 0, 0, 0); tick();
        set_issue(1, 1, 5'd0, 0, 0, 32'h1000, 32'h2000); tick();
        plan_val = 32'h9; set_issue(1, 0, 5'd8, 0, 0, 0, 0); tick();
        idle();
        set_wb(1, 0, 32'h5, 1, 1, 32'h1); tick();
        idle();
        chk("mp_flush", flush, 1);
        chk("mp_flush_pc", flush_pc, 32'h1000);
        chk("mp_cm_valid", cm_valid, 2'b11);
        chk("mp_cm_rd", cm_rd, {5'd0, 5'd7});
        set_issue(1, 3, 5'd4, 32'hDEAD, 0, 0, 0);
        set_wb(1, 2, 32'h9, 0, 0, 0);
        tick();
        idle();
        q_tag1 = 2;
        #1;
        chk("mp_count", count, 0);
        chk("mp_issue_tag", issue_tag, 0);
        chk("mp_flush_clear", flush, 0);
        chk("mp_cm_clear", cm_valid, 0);
        chk("mp_wb_dropped", q_rdy1, 0);

        // two correctly predicted branches retire one per cycle
        set_issue(1, 1, 5'd0, 0, 1, 32'h3000, 32'h3004); tick();
        set_issue(1, 1, 5'd0, 0, 0, 32'h4000, 32'h4004); tick();
        idle();
        set_wb(1, 0, 32'h1, 1, 1, 32'h0); tick();
        idle();
        chk("br2_lane", cm_valid, 2'b01);
        chk("br2_flush", flush, 0);
        tick();
        chk("br2_second", cm_valid, 2'b01);
        chk("br2_second_tag", cm_tag[IW-1:0], 1);
        tick();
        set_issue(1, 1, 5'd0, 0, 1, 32'h5000, 32'h2004); tick();
        idle();
        set_wb(1, 2, 32'h0, 0, 0, 0); tick();
        idle();
        chk("nt_flush", flush, 1);
        chk("nt_flush_pc", flush_pc, 32'h2004);
        tick();
        chk("nt_count", count, 0);

        // store at head waits for the LSB handshake
        do_reset();
        set_issue(1, 2, 5'd0, 0, 0, 0, 0); tick();
        plan_val = 32'h99; set_issue(1, 0, 5'd9, 0, 0, 0, 0); tick();
        idle();
        set_wb(1, 0, 32'h4000, 0, 0, 0); tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("st_wait_commit", st_commit, 1);
            chk("st_wait_valid", cm_valid, 0);
            tick();
        end
        chk("st_wait_count", count, 2);
        st_ack = 1;
        #1;
        chk("st_ack_valid", cm_valid, 2'b01);
        chk("st_ack_commit", st_commit, 1);
        tick();
        idle();
        chk("st_done_count", count, 1);
        chk("st_done_commit", st_commit, 0);
        set_wb(1, 1, 32'h99, 0, 0, 0); tick();
        idle();
        tick();
        chk("st_drained", count, 0);

        // long stream wraps the tags; reset mid-stream empties the ROB
        do_reset();
        for (int c = 0, got = 0; c < 200 && got < 40; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_issue(1, 3, 5'((got % 31) + 1), $urandom, 0, 0, 0);
                got++;
            end else idle();
            tick();
        end
        idle();
        for (int c = 0; c < 10 && count != 0; c++) tick();
        chk("wrap_drained", count, 0);
        chk("wrap_sb_empty", sb.size(), 0);
        for (int i = 0; i < 3; i++) begin
            plan_val = 32'h7;
            set_issue(1, 0, 5'd2, 0, 0, 0, 0);
            tick();
        end
        rst_in = 1;
        tick();
        rst_in = 0;
        idle();
        chk("midrst_count", count, 0);
        chk("midrst_cm_valid", cm_valid, 0);
        chk("midrst_issue_tag", issue_tag, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
